// File: rtl/lb_negedge_pulse_gen.sv
// Turns single-cycle request pulses into active-low strobes of LOW_CYCLES clocks,
// each followed by at least GAP_CYCLES clocks high; extra requests queue in a saturating counter.
module lb_negedge_pulse_gen #(
    parameter int LOW_CYCLES = 4,
    parameter int GAP_CYCLES = 2,
    parameter int PEND_W     = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic cs,
    input  logic pulse_in,
    output logic signal_out,
    output logic busy,
    output logic overflow
);

    localparam int MAX_CYCLES = (LOW_CYCLES > GAP_CYCLES) ? LOW_CYCLES : GAP_CYCLES;
    localparam int TIMER_W    = $clog2(MAX_CYCLES) + 1;

    localparam logic [TIMER_W-1:0] LOW_LOAD = TIMER_W'(LOW_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD = TIMER_W'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0]  PEND_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        GAP
    } state_t;

    state_t             state, state_nxt;
    logic [TIMER_W-1:0] timer, timer_nxt;
    logic [PEND_W-1:0]  pending, pending_nxt;
    logic               overflow_nxt;
    logic               queue_req;
    logic               acc;

    assign acc = cs & pulse_in;

    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer;
        pending_nxt  = pending;
        overflow_nxt = 1'b0;
        queue_req    = 1'b0;

        if (cs) begin
            case (state)
                IDLE: begin
                    if (acc) begin
                        state_nxt = LOW;
                        timer_nxt = LOW_LOAD;
                    end
                end
                LOW: begin
                    queue_req = acc;
                    if (timer != '0) begin
                        timer_nxt = timer - TIMER_W'(1);
                    end else begin
                        state_nxt = GAP;
                        timer_nxt = GAP_LOAD;
                    end
                end
                GAP: begin
                    if (timer != '0) begin
                        timer_nxt = timer - TIMER_W'(1);
                        queue_req = acc;
                    end else if ((pending != '0) || acc) begin
                        // A request arriving on the exit edge is consumed directly, never queued.
                        state_nxt = LOW;
                        timer_nxt = LOW_LOAD;
                        if (!acc) begin
                            pending_nxt = pending - PEND_W'(1);
                        end
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end
            endcase

            if (queue_req) begin
                if (pending != PEND_MAX) begin
                    pending_nxt = pending + PEND_W'(1);
                end else begin
                    overflow_nxt = 1'b1;
                end
            end
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            timer      <= '0;
            pending    <= '0;
            signal_out <= 1'b1;
            busy       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            pending    <= pending_nxt;
            signal_out <= (state_nxt != LOW);
            busy       <= (state_nxt != IDLE);
            overflow   <= overflow_nxt;
        end
    end

endmodule

// File: tb/tb_lb_negedge_pulse_gen.sv
// Directed bench for lb_negedge_pulse_gen: a negedge monitor measures every strobe and
// pops the expected low width from a scoreboard queue filled as requests are issued.
module tb_lb_negedge_pulse_gen;

    localparam int LOW_CYCLES = 4;
    localparam int GAP_CYCLES = 2;
    localparam int PEND_W     = 3;

    logic clk;
    logic reset;
    logic cs;
    logic pulse_in;
    logic signal_out;
    logic busy;
    logic overflow;

    int num_checks = 0;
    int num_errors = 0;

    int sb_q[$];
    int strobe_count = 0;
    int ovf_count    = 0;
    int low_cnt      = 0;
    int high_cnt     = 0;
    bit in_low       = 1'b0;
    bit contiguous   = 1'b0;

    int cycles;
    int strobe_base;
    int ovf_base;

    lb_negedge_pulse_gen #(
        .LOW_CYCLES(LOW_CYCLES),
        .GAP_CYCLES(GAP_CYCLES),
        .PEND_W    (PEND_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cs        (cs),
        .pulse_in  (pulse_in),
        .signal_out(signal_out),
        .busy      (busy),
        .overflow  (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        num_checks++;
        assert (observed === expected)
        else begin
            num_errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Holds pulse_in high for n consecutive rising edges; returns at the negedge after the last.
    task automatic apply_stimulus(input int n);
        pulse_in = 1'b1;
        repeat (n) @(negedge clk);
        pulse_in = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy !== 1'b0 && n < 300) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Acts as the downstream negedge detector and measures each strobe's low and gap widths.
    always @(negedge clk) begin
        if (!reset) begin
            in_low     = 1'b0;
            low_cnt    = 0;
            high_cnt   = 0;
            contiguous = 1'b0;
        end else begin
            if (overflow === 1'b1) ovf_count++;
            if (signal_out === 1'b0) begin
                if (!in_low) begin
                    strobe_count++;
                    if (contiguous) check_output("gap_width", high_cnt, GAP_CYCLES);
                    in_low  = 1'b1;
                    low_cnt = 0;
                end
                low_cnt++;
            end else begin
                if (in_low) begin
                    in_low     = 1'b0;
                    high_cnt   = 0;
                    contiguous = 1'b1;
                    check_output("strobe_expected", (sb_q.size() != 0), 1);
                    if (sb_q.size() != 0) check_output("low_width", low_cnt, sb_q.pop_front());
                end
                if (busy !== 1'b1) contiguous = 1'b0;
                high_cnt++;
            end
        end
    end

    initial begin
        reset    = 1'b1;
        cs       = 1'b1;
        pulse_in = 1'b0;
        #1 reset = 1'b0;
        #2;
        check_output("rst_signal_out", signal_out, 1);
        check_output("rst_busy", busy, 0);
        check_output("rst_overflow", overflow, 0);
        check_output("rst_pending", dut.pending, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Idle after reset release
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_output("idle_signal_out", signal_out, 1);
            check_output("idle_busy", busy, 0);
            check_output("idle_overflow", overflow, 0);
        end

        // Single request
        strobe_base = strobe_count;
        ovf_base    = ovf_count;
        sb_q.push_back(LOW_CYCLES);
        apply_stimulus(1);
        check_output("latency_signal_out", signal_out, 0);
        check_output("latency_busy", busy, 1);
        wait_idle(cycles);
        check_output("single_busy_len", cycles, LOW_CYCLES + GAP_CYCLES);
        repeat (2) @(negedge clk);
        check_output("single_strobes", strobe_count - strobe_base, 1);
        check_output("single_sb_empty", sb_q.size(), 0);

        // Three requests back-to-back
        strobe_base = strobe_count;
        repeat (3) sb_q.push_back(LOW_CYCLES);
        apply_stimulus(3);
        check_output("queue_pending", dut.pending, 2);
        wait_idle(cycles);
        check_output("queue_busy_len", cycles + 2, 3 * (LOW_CYCLES + GAP_CYCLES));
        repeat (2) @(negedge clk);
        check_output("queue_strobes", strobe_count - strobe_base, 3);
        check_output("queue_sb_empty", sb_q.size(), 0);

        // 11 requests on consecutive edges: the one on the first GAP exit edge is consumed
        // directly, the counter saturates at 7 and the last two are dropped.
        strobe_base = strobe_count;
        ovf_base    = ovf_count;
        repeat (9) sb_q.push_back(LOW_CYCLES);
        apply_stimulus(11);
        check_output("ovf_pending_sat", dut.pending, 7);
        wait_idle(cycles);
        check_output("ovf_busy_len", cycles + 10, 9 * (LOW_CYCLES + GAP_CYCLES));
        repeat (2) @(negedge clk);
        check_output("ovf_pulses", ovf_count - ovf_base, 2);
        check_output("ovf_strobes", strobe_count - strobe_base, 9);
        check_output("ovf_sb_empty", sb_q.size(), 0);

        // Chip-select stall in the middle of LOW with requests held high
        strobe_base = strobe_count;
        ovf_base    = ovf_count;
        sb_q.push_back(LOW_CYCLES + 5);
        apply_stimulus(1);
        @(negedge clk);
        cs       = 1'b0;
        pulse_in = 1'b1;
        repeat (5) @(negedge clk);
        check_output("stall_overflow", overflow, 0);
        check_output("stall_pending", dut.pending, 0);
        cs       = 1'b1;
        pulse_in = 1'b0;
        wait_idle(cycles);
        check_output("stall_busy_len", cycles + 6, LOW_CYCLES + 5 + GAP_CYCLES);
        repeat (2) @(negedge clk);
        check_output("stall_strobes", strobe_count - strobe_base, 1);
        check_output("stall_ovf", ovf_count - ovf_base, 0);
        check_output("stall_sb_empty", sb_q.size(), 0);

        // Async reset while a strobe is low with two requests queued
        apply_stimulus(3);
        check_output("mid_pending", dut.pending, 2);
        check_output("mid_signal_out", signal_out, 0);
        #1 reset = 1'b0;
        #1;
        check_output("async_signal_out", signal_out, 1);
        check_output("async_busy", busy, 0);
        check_output("async_pending", dut.pending, 0);
        repeat (2) @(negedge clk);
        reset       = 1'b1;
        strobe_base = strobe_count;
        repeat (30) @(negedge clk);
        check_output("post_reset_strobes", strobe_count - strobe_base, 0);
        check_output("post_reset_busy", busy, 0);
        check_output("post_reset_signal_out", signal_out, 1);

        $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
        $finish;
    end

endmodule
